// File: rtl/push_btn_array_pkg.sv
// Shared opcode and state definitions for the multi-channel push-button controller.
// Imported by push_btn_array and push_btn_array_debounce.
package push_btn_array_pkg;

  localparam logic [3:0] PushBtnArray_NOP   = 4'h0;
  localparam logic [3:0] PushBtnArray_RDBS  = 4'h1;
  localparam logic [3:0] PushBtnArray_RDCH  = 4'h2;
  localparam logic [3:0] PushBtnArray_CLR   = 4'h3;
  localparam logic [3:0] PushBtnArray_MASK  = 4'h4;
  localparam logic [3:0] PushBtnArray_RDCNT = 4'h5;

  typedef enum logic [1:0] {
    PushBtnArray_State_Reset = 2'd0,
    PushBtnArray_State_Ready = 2'd1,
    PushBtnArray_State_Error = 2'd2
  } state_t;

  // A channel selector is only legal when it addresses an existing button.
  function automatic logic chan_valid(input logic [2:0] c, input int n);
    return int'(c) < n;
  endfunction

endpackage

// File: rtl/push_btn_array_if.sv
// Instruction bus and button/result signals of the push-button controller.
// The master side issues instructions and drives the raw buttons; the slave is the controller.
interface push_btn_array_if #(
  parameter int Channels = 4
);
  logic [11:0]         inst;
  logic                inst_en;
  logic [Channels-1:0] buttons;
  logic [Channels-1:0] button_status;
  logic [7:0]          press_count;

  modport master (
    output inst, inst_en, buttons,
    input  button_status, press_count
  );

  modport slave (
    input  inst, inst_en, buttons,
    output button_status, press_count
  );
endinterface

// File: rtl/push_btn_array_debounce.sv
// One-channel debouncer: 2-flop synchroniser, stability counter, stable level and a
// single-cycle press pulse on every accepted 0->1 transition.
module push_btn_array_debounce #(
  parameter int Wait = 40000,
  parameter int Size = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pressed
);

  logic            sync_p0;
  logic            sync_p1;
  logic            level;
  logic [Size-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      pressed <= 1'b0;
      // Any sample that agrees with the stable level restarts the stability window.
      if (sync_p1 != level) begin
        if (cnt == Size'(Wait - 1)) begin
          level   <= sync_p1;
          cnt     <= '0;
          pressed <= sync_p1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/push_btn_array.sv
// Multi-channel push-button controller answering 12-bit read/clear/mask instructions.
// Optional per-channel press counters and the RDCNT opcode: define PUSHBTNARRAY_COUNT_EN.
module push_btn_array
  import push_btn_array_pkg::*;
#(
  parameter int Channels     = 4,
  parameter int DebounceWait = 40000,
  parameter int DebounceSize = 16
) (
  input  logic clock,
  input  logic reset,
  push_btn_array_if.slave bus
);

  state_t              state;
  logic [Channels-1:0] pressed;
  logic [Channels-1:0] int_status;
  logic [Channels-1:0] button_status;
  logic [Channels-1:0] mask;
  logic [Channels-1:0] sel;
  logic [Channels-1:0] pm;
  logic [Channels-1:0] m_op;
  logic [3:0]          op_eff;
  logic [2:0]          chan;
  logic                chan_ok;
  logic                op_ok;
  logic                go_err;

  for (genvar i = 0; i < Channels; i++) begin : g_db
    push_btn_array_debounce #(
      .Wait (DebounceWait),
      .Size (DebounceSize)
    ) u_db (
      .clock   (clock),
      .reset   (reset),
      .btn     (bus.buttons[i]),
      .pressed (pressed[i])
    );
  end

  always_comb begin
    op_eff  = bus.inst_en ? bus.inst[11:8] : PushBtnArray_NOP;
    chan    = bus.inst[2:0];
    chan_ok = chan_valid(chan, Channels);
    m_op    = bus.inst[Channels-1:0];
    pm      = pressed & mask;
    sel     = '0;
    for (int i = 0; i < Channels; i++) begin
      if (chan == 3'(i)) sel[i] = 1'b1;
    end
    op_ok = 1'b0;
    case (op_eff)
      PushBtnArray_NOP, PushBtnArray_RDBS,
      PushBtnArray_CLR, PushBtnArray_MASK: op_ok = 1'b1;
      PushBtnArray_RDCH:                   op_ok = chan_ok;
`ifdef PUSHBTNARRAY_COUNT_EN
      PushBtnArray_RDCNT:                  op_ok = chan_ok;
`endif
      default:                             op_ok = 1'b0;
    endcase
    go_err = (state == PushBtnArray_State_Ready) && !op_ok;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= PushBtnArray_State_Reset;
      int_status    <= '0;
      button_status <= '0;
      mask          <= '1;
    end else begin
      case (state)
        PushBtnArray_State_Reset: state <= PushBtnArray_State_Ready;
        PushBtnArray_State_Ready: begin
          if (go_err) begin
            state         <= PushBtnArray_State_Error;
            int_status    <= '0;
            button_status <= '0;
          end else begin
            case (op_eff)
              PushBtnArray_RDBS: begin
                button_status <= int_status;
                int_status    <= pm;
              end
              // Only the selected channel is consumed; the rest keep accumulating.
              PushBtnArray_RDCH: begin
                button_status <= int_status & sel;
                int_status    <= (int_status & ~sel) | pm;
              end
              PushBtnArray_CLR: begin
                button_status <= '0;
                int_status    <= pm;
              end
              PushBtnArray_MASK: begin
                mask       <= m_op;
                int_status <= (int_status | pressed) & m_op;
              end
              default: int_status <= int_status | pm;
            endcase
          end
        end
        PushBtnArray_State_Error: begin
          int_status    <= '0;
          button_status <= '0;
        end
        default: state <= PushBtnArray_State_Error;
      endcase
    end
  end

  assign bus.button_status = button_status;

`ifdef PUSHBTNARRAY_COUNT_EN
  logic [7:0]          cnt [Channels];
  logic [7:0]          cnt_sel;
  logic [7:0]          press_count;
  logic [Channels-1:0] cnt_inc;

  always_comb begin
    // A MASK instruction already applies its new mask to presses in the same cycle.
    cnt_inc = pressed & ((op_eff == PushBtnArray_MASK) ? m_op : mask);
    cnt_sel = 8'h00;
    for (int i = 0; i < Channels; i++) begin
      if (sel[i]) cnt_sel = cnt[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < Channels; i++) cnt[i] <= 8'h00;
      press_count <= 8'h00;
    end else if (state == PushBtnArray_State_Error || go_err) begin
      press_count <= 8'h00;
    end else if (state == PushBtnArray_State_Ready) begin
      for (int i = 0; i < Channels; i++) begin
        if (op_eff == PushBtnArray_CLR) begin
          cnt[i] <= 8'h00;
        end else if (op_eff == PushBtnArray_RDCNT && sel[i]) begin
          cnt[i] <= {7'b0, cnt_inc[i]};
        end else if (cnt_inc[i] && cnt[i] != 8'hFF) begin
          cnt[i] <= cnt[i] + 8'h01;
        end
      end
      if (op_eff == PushBtnArray_RDCNT) press_count <= cnt_sel;
    end
  end

  assign bus.press_count = press_count;
`else
  assign bus.press_count = 8'h00;
`endif

endmodule

// File: tb/tb_push_btn_array.sv
// Randomised self-checking bench for push_btn_array (Channels=4, DebounceWait=4, DebounceSize=3)
// against a cycle-level behavioural model of the debounce and instruction rules.
module tb_push_btn_array;

  localparam int WAIT = 4;
  localparam int ST_RESET = 0, ST_READY = 1, ST_ERROR = 2;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] btn_v;

  always #5 clock = ~clock;

  push_btn_array_if #(.Channels(4)) bus ();

  push_btn_array #(
    .Channels     (4),
    .DebounceWait (WAIT),
    .DebounceSize (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state
  int         m_state;
  logic [3:0] m_int, m_bs, m_mask, m_pressed, m_stable;
  int         m_run [4];
  int         m_cnt [4];
  logic [7:0] m_pc;
  logic [3:0] dq [$];

  task automatic model_step(input logic r, input logic en, input logic [11:0] ins,
                            input logic [3:0] btn);
    logic [3:0] pm, add, seen, m, o;
    int c;
    bit err;
    if (!r) begin
      m_state = ST_RESET; m_int = 0; m_bs = 0; m_mask = 4'hF; m_pc = 0;
      m_pressed = 0; m_stable = 0;
      for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_run[i] = 0; end
      dq.delete(); dq.push_back(4'h0); dq.push_back(4'h0);
      return;
    end
    pm = m_pressed & m_mask; add = pm; err = 0;
    o = en ? ins[11:8] : 4'h0;
    c = int'(ins[2:0]);
    if (m_state == ST_RESET) begin
      m_state = ST_READY;
    end else if (m_state == ST_READY) begin
      case (o)
        4'h0: m_int = m_int | pm;
        4'h1: begin m_bs = m_int; m_int = pm; end
        4'h2: if (c > 3) err = 1;
              else begin m_bs = 4'h0; m_bs[c] = m_int[c]; m_int = m_int | pm; m_int[c] = pm[c]; end
        4'h3: begin m_int = pm; m_bs = 4'h0; add = 4'h0;
                for (int i = 0; i < 4; i++) m_cnt[i] = 0; end
        4'h4: begin m = ins[3:0]; m_mask = m; add = m_pressed & m; m_int = (m_int | m_pressed) & m; end
`ifdef PUSHBTNARRAY_COUNT_EN
        4'h5: if (c > 3) err = 1; else begin m_pc = 8'(m_cnt[c]); m_int = m_int | pm; end
`endif
        default: err = 1;
      endcase
      if (err) begin
        m_state = ST_ERROR; m_bs = 0; m_int = 0; m_pc = 0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (o == 4'h5 && i == c) m_cnt[i] = add[i] ? 1 : 0;
          else if (add[i] && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end else begin
      m_bs = 0; m_int = 0; m_pc = 0;
    end
    // A level is accepted once WAIT consecutive synchronised samples disagree with it.
    dq.push_back(btn);
    seen = dq.pop_front();
    m_pressed = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (seen[i] != m_stable[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == WAIT) begin
          m_stable[i] = seen[i]; m_run[i] = 0; m_pressed[i] = seen[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic tick(input logic r, input logic en, input logic [11:0] ins);
    reset = r; bus.inst_en = en; bus.inst = ins; bus.buttons = btn_v;
    @(posedge clock);
    model_step(r, en, ins, btn_v);
    #1;
  endtask

  task automatic op(input logic [3:0] o, input logic [7:0] arg);
    tick(1'b1, 1'b1, {o, arg});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 12'h000);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 12'h000);
    tick(1'b1, 1'b0, 12'h000);
  endtask

  task automatic press(input logic [3:0] b);
    btn_v = b; idle(8);
    btn_v = 4'h0; idle(8);
  endtask

  task automatic test_reset();
    btn_v = 4'h0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 12'h000);
    total++;
    if (bus.button_status !== 4'b0000) begin
      bad++; $display("FAIL reset_status got=%b exp=0000", bus.button_status);
    end
    total++;
    if (bus.press_count !== 8'h00) begin
      bad++; $display("FAIL reset_count got=%h exp=00", bus.press_count);
    end
    tick(1'b1, 1'b0, 12'h000);
    op(4'h1, 8'h00);
    total++;
    if (bus.button_status !== 4'b0000 || bus.button_status !== m_bs) begin
      bad++; $display("FAIL reset_rdbs got=%b exp=0000", bus.button_status);
    end
  endtask

  task automatic test_glitch();
    int first = 0;
    btn_v = 4'b0100; idle(1);
    btn_v = 4'b0000; idle(1);
    btn_v = 4'b0100; idle(1);
    // Pulse 2+WAIT cycles after the edge, latched one later, visible on the following read.
    for (int k = 1; k <= 12; k++) begin
      op(4'h1, 8'h00);
      total++;
      if (bus.button_status !== m_bs) begin
        bad++; $display("FAIL glitch_read k=%0d got=%b exp=%b", k, bus.button_status, m_bs);
      end
      if (first == 0 && bus.button_status[2]) first = k;
    end
    total++;
    if (first != 7) begin
      bad++; $display("FAIL glitch_latency got=%0d exp=7", first);
    end
    op(4'h1, 8'h00);
    total++;
    if (bus.button_status !== 4'b0000) begin
      bad++; $display("FAIL glitch_reread got=%b exp=0000", bus.button_status);
    end
    btn_v = 4'h0; idle(8);
  endtask

  task automatic test_mask();
    op(4'h3, 8'h00);
    op(4'h4, 8'h0E);
    press(4'b0011);
    op(4'h1, 8'h00);
    total++;
    if (bus.button_status !== 4'b0010 || bus.button_status !== m_bs) begin
      bad++; $display("FAIL mask_read got=%b exp=0010", bus.button_status);
    end
  endtask

  task automatic test_rdch();
    bit found = 0;
    op(4'h3, 8'h00);
    press(4'b0010);
    btn_v = 4'b0010;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_pressed[1]) found = 1; else idle(1);
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL rdch_pulse got=none exp=pulse");
    end
    op(4'h2, 8'h01);
    total++;
    if (bus.button_status !== 4'b0010 || bus.button_status !== m_bs) begin
      bad++; $display("FAIL rdch_first got=%b exp=0010", bus.button_status);
    end
    op(4'h2, 8'h01);
    total++;
    if (bus.button_status !== 4'b0010 || bus.button_status !== m_bs) begin
      bad++; $display("FAIL rdch_second got=%b exp=0010", bus.button_status);
    end
    btn_v = 4'h0; idle(8);
  endtask

`ifdef PUSHBTNARRAY_COUNT_EN
  task automatic test_count();
    op(4'h4, 8'hFF);
    op(4'h3, 8'h00);
    for (int i = 0; i < 3; i++) press(4'b1000);
    op(4'h5, 8'h03);
    total++;
    if (bus.press_count !== 8'h03) begin
      bad++; $display("FAIL count_first got=%h exp=03", bus.press_count);
    end
    op(4'h5, 8'h03);
    total++;
    if (bus.press_count !== 8'h00) begin
      bad++; $display("FAIL count_second got=%h exp=00", bus.press_count);
    end
  endtask
`endif

  task automatic test_random();
    int hold = 0;
    int r;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (hold == 0) begin btn_v = 4'($urandom_range(0, 15)); hold = $urandom_range(1, 9); end
      hold--;
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 199) == 0) tick(1'b0, 1'b0, 12'h000);
      else case (r)
        5: op(4'h1, 8'($urandom));
        6: op(4'h2, 8'($urandom_range(0, 3)));
        7: if ($urandom_range(0, 2) == 0) op(4'h3, 8'h00); else idle(1);
        8: op(4'h4, 8'($urandom));
`ifdef PUSHBTNARRAY_COUNT_EN
        9: op(4'h5, 8'($urandom_range(0, 3)));
`else
        9: op(4'h1, 8'h00);
`endif
        default: tick(1'b1, 1'($urandom), 12'h000);
      endcase
      total++;
      if (bus.button_status !== m_bs) begin
        bad++; $display("FAIL rand_status n=%0d got=%b exp=%b", n, bus.button_status, m_bs);
      end
      total++;
      if (bus.press_count !== m_pc) begin
        bad++; $display("FAIL rand_count n=%0d got=%h exp=%h", n, bus.press_count, m_pc);
      end
    end
    btn_v = 4'h0; idle(8);
  endtask

  task automatic test_error();
    do_reset();
    op(4'h9, 8'h00);
    press(4'b1111);
    op(4'h1, 8'h00);
    total++;
    if (bus.button_status !== 4'b0000 || bus.button_status !== m_bs) begin
      bad++; $display("FAIL err_opcode got=%b exp=0000", bus.button_status);
    end
    do_reset();
    op(4'h2, 8'h05);
    press(4'b0001);
    op(4'h1, 8'h00);
    total++;
    if (bus.button_status !== 4'b0000 || bus.press_count !== 8'h00) begin
      bad++; $display("FAIL err_rdch got=%b/%h exp=0000/00", bus.button_status, bus.press_count);
    end
`ifndef PUSHBTNARRAY_COUNT_EN
    do_reset();
    op(4'h5, 8'h00);
    press(4'b0001);
    op(4'h1, 8'h00);
    total++;
    if (bus.button_status !== 4'b0000) begin
      bad++; $display("FAIL err_rdcnt got=%b exp=0000", bus.button_status);
    end
`endif
    do_reset();
    press(4'b0001);
    op(4'h1, 8'h00);
    total++;
    if (bus.button_status !== 4'b0001 || bus.button_status !== m_bs) begin
      bad++; $display("FAIL err_recover got=%b exp=0001", bus.button_status);
    end
  endtask

  initial begin
    reset = 1'b0; bus.inst_en = 1'b0; bus.inst = 12'h000; bus.buttons = 4'h0; btn_v = 4'h0;
    #1;
    test_reset();
    test_glitch();
    test_mask();
    test_rdch();
`ifdef PUSHBTNARRAY_COUNT_EN
    test_count();
`endif
    test_random();
    test_error();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
